// File: rtl/matrix_mem_pkg.sv
// Shared types and constants for the matrix multiplier's memory-side responder.
// Stall LFSR constants are only consumed when MATRIX_MEM_STALL_EN is defined.
package matrix_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mm_state_t;

    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
    localparam int          WORD_BYTES = 4;

    // x^4 + x^3 + 1, shifted left with feedback into bit 0
    localparam logic [3:0]  LFSR_SEED  = 4'b1001;
    localparam logic [3:0]  LFSR_TAPS  = 4'b1100;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/matrix_mem_ram.sv
// Single-port synchronous word RAM, DEPTH x 32, read data registered (1-cycle read).
module matrix_mem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/matrix_mem_responder.sv
// Word-transaction memory responder with backdoor port; done pulses LATENCY cycles after accept.
// Optional MATRIX_MEM_STALL_EN adds LFSR-driven extra wait cycles.
module matrix_mem_responder
    import matrix_mem_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_memory_transaction,
    input  logic                     mem_we,
    input  logic [31:0]              address_in,
    input  logic [31:0]              data_in,
    output logic [31:0]              data_out,
    output logic                     done_memory_transaction,
    output logic                     err,
    input  logic                     bk_en,
    input  logic                     bk_we,
    input  logic [$clog2(DEPTH)-1:0] bk_addr,
    input  logic [31:0]              bk_wdata,
    output logic [31:0]              bk_rdata
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] RANGE = 32'(WORD_BYTES * DEPTH);
    localparam logic [4:0]  LAT   = 5'(LATENCY);

    mm_state_t   r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_addr, r_wdata, r_dout, r_bk_hold;
    logic        r_we, r_resp_rd, r_resp_bad, r_err, r_bk_vld;

    logic          w_idle, w_issue, w_step, w_cnt_done, w_bad, w_we;
    logic [31:0]   w_addr, w_wdata, w_offset, w_ram_rdata, w_ram_wdata, w_resp_data;
    logic          w_ram_en, w_ram_we;
    logic [AW-1:0] w_ram_addr;

`ifdef MATRIX_MEM_STALL_EN
    logic [3:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_step = r_lfsr[0];
`else
    assign w_step = 1'b1;
`endif

    // In IDLE the access may issue straight from the inputs (LATENCY == 1)
    assign w_idle     = (r_state == IDLE);
    assign w_addr     = w_idle ? address_in : r_addr;
    assign w_we       = w_idle ? mem_we     : r_we;
    assign w_wdata    = w_idle ? data_in    : r_wdata;
    assign w_offset   = w_addr - BASE_ADDR;
    assign w_bad      = (w_offset[1:0] != 2'b00) || (w_offset >= RANGE);
    assign w_cnt_done = ({1'b0, r_cnt} + 5'd2) >= LAT;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_memory_transaction) begin
                    w_cnt_nxt = '0;
                    if (LATENCY == 1 && !bk_en) begin
                        w_issue     = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (w_step) begin
                    if (!w_cnt_done) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (!bk_en) begin
                        w_issue     = 1'b1;
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The RAM access is issued on the edge entering RESP so registered read data lands in RESP
    assign w_ram_en    = bk_en || (w_issue && !w_bad);
    assign w_ram_we    = bk_en ? bk_we    : w_we;
    assign w_ram_addr  = bk_en ? bk_addr  : w_offset[2 +: AW];
    assign w_ram_wdata = bk_en ? bk_wdata : w_wdata;

    matrix_mem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_resp_rd  <= 1'b0;
            r_resp_bad <= 1'b0;
            r_err      <= 1'b0;
            r_dout     <= '0;
            r_bk_vld   <= 1'b0;
            r_bk_hold  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bk_vld <= bk_en && !bk_we;
            if (w_idle && start_memory_transaction) begin
                r_addr  <= address_in;
                r_we    <= mem_we;
                r_wdata <= data_in;
            end
            if (w_issue) begin
                r_resp_rd  <= !w_we;
                r_resp_bad <= w_bad;
                if (w_bad) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == RESP && r_resp_rd) begin
                r_dout <= w_resp_data;
            end
            if (r_bk_vld) begin
                r_bk_hold <= w_ram_rdata;
            end
        end
    end

    assign w_resp_data             = r_resp_bad ? ERR_DATA : w_ram_rdata;
    assign done_memory_transaction = (r_state == RESP);
    assign data_out                = (r_state == RESP && r_resp_rd) ? w_resp_data : r_dout;
    assign err                     = r_err;
    assign bk_rdata                = r_bk_vld ? w_ram_rdata : r_bk_hold;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Bench for matrix_mem_responder: transaction-level model plus directed vectors.
module tb_matrix_mem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst, start_req, mem_we, done, err, bk_en, bk_we;
    logic [31:0] address_in, data_in, data_out, bk_wdata, bk_rdata;
    logic [5:0]  bk_addr;

    always #5 clk = ~clk;

    matrix_mem_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start_memory_transaction (start_req),
        .mem_we                   (mem_we),
        .address_in               (address_in),
        .data_in                  (data_in),
        .data_out                 (data_out),
        .done_memory_transaction  (done),
        .err                      (err),
        .bk_en                    (bk_en),
        .bk_we                    (bk_we),
        .bk_addr                  (bk_addr),
        .bk_wdata                 (bk_wdata),
        .bk_rdata                 (bk_rdata)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Transaction-level model: one outstanding request, completion edge known from LATENCY
    int          cyc = 0;
    bit          pending = 1'b0, fin = 1'b0;
    logic        t_we;
    logic [31:0] t_addr, t_wdata;
    int          resp_edge, acc_edge;
    logic        err_m = 1'b0;
    logic [31:0] dout_m = '0, bk_m = '0;
    logic [31:0] mem_m [DEPTH];
    int          n_done = 0;
    int          cexp [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pending = 1'b0;
            fin     = 1'b0;
            err_m   = 1'b0;
            dout_m  = '0;
            bk_m    = '0;
        end else begin
            if (bk_en && !bk_we) bk_m = mem_m[bk_addr];
            if (bk_en && bk_we)  mem_m[bk_addr] = bk_wdata;
            if (fin) begin
                pending = 1'b0;
                fin     = 1'b0;
            end else if (pending) begin
                if (bk_en && cyc == resp_edge) resp_edge++;
            end else if (start_req) begin
                pending   = 1'b1;
                t_we      = mem_we;
                t_addr    = address_in;
                t_wdata   = data_in;
                acc_edge  = cyc;
                resp_edge = cyc + LAT - 1;
                if (bk_en && cyc == resp_edge) resp_edge++;
            end
        end
    end

    always @(negedge clk) begin
        logic        fire;
        logic [31:0] off;
        logic        bad;
        if (rst) begin
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_data_out", data_out, 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_bk_rdata", bk_rdata, 32'd0);
        end else begin
`ifdef MATRIX_MEM_STALL_EN
            fire = pending && !fin && (done === 1'b1);
`else
            fire = pending && !fin && (cyc == resp_edge);
`endif
            chk("done", 32'(done), 32'(fire));
            if (fire) begin
                fin = 1'b1;
                chk("latency_min", 32'((cyc - acc_edge + 1) >= LAT), 32'd1);
                off = t_addr - BASE;
                bad = (off[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
                if (bad) begin
                    err_m = 1'b1;
                    if (!t_we) dout_m = 32'hDEAD_BEEF;
                end else if (t_we) begin
                    mem_m[int'(off >> 2)] = t_wdata;
                end else begin
                    dout_m = mem_m[int'(off >> 2)];
                end
            end
            chk("data_out", data_out, dout_m);
            chk("err", 32'(err), 32'(err_m));
            chk("bk_rdata", bk_rdata, bk_m);
        end
        if (done === 1'b1) n_done++;
    end

    task automatic bk_write(input int idx, input logic [31:0] v);
        @(posedge clk); #1;
        bk_en = 1'b1; bk_we = 1'b1; bk_addr = 6'(idx); bk_wdata = v;
        @(posedge clk); #1;
        bk_en = 1'b0; bk_we = 1'b0;
    endtask

    task automatic bk_read(input int idx, output logic [31:0] v);
        @(posedge clk); #1;
        bk_en = 1'b1; bk_we = 1'b0; bk_addr = 6'(idx);
        @(posedge clk); #1;
        bk_en = 1'b0;
        v = bk_rdata;
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input bit collide, output logic [31:0] rd, output int lat);
        int n;
        int k;
        @(posedge clk); #1;
        start_req = 1'b1; mem_we = we; address_in = a; data_in = d;
        @(posedge clk); #1;
        k = cyc;
        start_req = 1'b0; mem_we = ~we; address_in = $urandom; data_in = $urandom;
        if (collide) begin
            bk_en = 1'b1; bk_we = 1'b0; bk_addr = 6'd0;
            @(posedge clk); #1;
            bk_en = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("txn_done_seen", 32'(done), 32'd1);
        rd  = data_out;
        lat = cyc - k + 1;
        chk("txn_latency_min", 32'(lat >= LAT), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd, v;
        logic [31:0] av [18];
        logic [31:0] cm;
        int lat, n, n0;
        rst = 1'b1; start_req = 1'b0; mem_we = 1'b0; address_in = '0; data_in = '0;
        bk_en = 1'b0; bk_we = 1'b0; bk_addr = '0; bk_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        bk_write(5, 32'h1234_5678);
        txn(1'b0, BASE + 32'd20, 32'd0, 1'b0, rd, lat);
        chk("read_idx5", rd, 32'h1234_5678);
`ifndef MATRIX_MEM_STALL_EN
        chk("read_latency", 32'(lat), 32'd2);
`endif

        txn(1'b1, BASE, 32'hCAFE_0001, 1'b0, rd, lat);
        bk_read(0, v);
        chk("write_then_bk_read", v, 32'hCAFE_0001);

        n0 = n_done;
        txn(1'b0, BASE + 32'd2, 32'd0, 1'b0, rd, lat);
        chk("misaligned_rdata", rd, 32'hDEAD_BEEF);
        chk("misaligned_err", 32'(err), 32'd1);
        bk_read(0, v);
        chk("misaligned_ram_kept", v, 32'hCAFE_0001);

        txn(1'b1, BASE + 32'(4 * DEPTH), 32'h5555_AAAA, 1'b0, rd, lat);
        chk("oor_write_one_done", 32'(n_done - n0), 32'd2);
        txn(1'b0, BASE - 32'd4, 32'd0, 1'b0, rd, lat);
        chk("below_base_rdata", rd, 32'hDEAD_BEEF);

        txn(1'b0, BASE + 32'd20, 32'd0, 1'b1, rd, lat);
        chk("collide_rdata", rd, 32'h1234_5678);
        chk("collide_bk_rdata", bk_rdata, 32'hCAFE_0001);
`ifndef MATRIX_MEM_STALL_EN
        chk("collide_latency", 32'(lat), 32'd3);
`endif
        chk("err_sticky", 32'(err), 32'd1);

        // Request held high across done: next address presented the cycle after done
        @(posedge clk); #1;
        start_req = 1'b1; mem_we = 1'b0; address_in = BASE + 32'd20;
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("held_req_first", data_out, 32'h1234_5678);
        @(posedge clk); #1;
        address_in = BASE;
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("held_req_second", data_out, 32'hCAFE_0001);
        @(posedge clk); #1;
        start_req = 1'b0;

        bk_write(7, 32'h7777_0007);
        n0 = n_done;
        @(posedge clk); #1;
        start_req = 1'b1; mem_we = 1'b1; address_in = BASE + 32'd28; data_in = 32'hDEAD_0000;
        @(posedge clk); #1;
        rst = 1'b1; start_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done - n0), 32'd0);
        chk("abort_err_cleared", 32'(err), 32'd0);
        chk("abort_data_out", data_out, 32'd0);
        bk_read(7, v);
        chk("abort_word_kept", v, 32'h7777_0007);

        // Multiplier-style run: 18 operand loads, 9 result stores
        for (int i = 0; i < 9; i++) begin
            bk_write(i, 32'(i + 1));
            bk_write(9 + i, 32'(9 - i));
        end
        for (int i = 0; i < 18; i++) begin
            txn(1'b0, BASE + 32'(4 * i), 32'd0, 1'b0, rd, lat);
            av[i] = rd;
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                cm = '0;
                for (int k = 0; k < 3; k++) cm = cm + av[3 * r + k] * av[9 + 3 * k + c];
                txn(1'b1, BASE + 32'(4 * (18 + 3 * r + c)), cm, 1'b0, rd, lat);
            end
        end
        for (int i = 0; i < 9; i++) begin
            bk_read(18 + i, v);
            chk($sformatf("c_matrix_%0d", i), v, 32'(cexp[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
